// File: rtl/stopwatch_pkg.sv
// Shared stopwatch display constants: mode encoding, segment patterns, anode idle.
package stopwatch_pkg;

  typedef enum logic {
    MODE_LIVE = 1'b0,
    MODE_HOLD = 1'b1
  } mode_t;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  localparam logic [3:0] AN_OFF   = 4'b1111;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-low seven-segment pattern; non-BCD shows a dash.
module bcd_to_seg
  import stopwatch_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // Table lookup; anything above 9 is flagged as a dash
  always_comb begin
    seg = SEG_DASH;
    case (nib)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/disp_sched.sv
// Display scheduler: scans the 4-digit display, chooses live time or a frozen
// split value, and blinks the display while the stopwatch is paused.
module disp_sched
  import stopwatch_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_TICKS = 125
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_enabled,
  input  logic        init_regs,
  input  logic        split,
  input  logic [15:0] time_bcd,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [RW-1:0] REF_MAX = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_TICKS - 1);

  logic [RW-1:0] ref_cnt;
  logic [1:0]    sel;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  mode_t         mode, mode_nxt;
  logic          capture;
  logic [15:0]   hold_reg;
  logic [15:0]   src;
  logic [3:0]    nib;
  logic [6:0]    seg_dec;
  logic          tick, paused, blank;

  assign tick   = (ref_cnt == REF_MAX);
  assign paused = ~count_enabled & ~init_regs;
  assign blank  = paused & ~blink_phase;
  assign src    = (mode == MODE_HOLD) ? hold_reg : time_bcd;
  assign nib    = src[{sel, 2'b00} +: 4];

  bcd_to_seg u_dec (
    .nib (nib),
    .seg (seg_dec)
  );

  // Digit-slot refresh divider and digit select; runs in every mode
  always_ff @(posedge clk) begin
    if (reset) begin
      ref_cnt <= '0;
      sel     <= 2'd0;
    end else if (tick) begin
      ref_cnt <= '0;
      sel     <= sel + 2'd1;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

  // Mode state register and split capture
  always_ff @(posedge clk) begin
    if (reset) begin
      mode     <= MODE_LIVE;
      hold_reg <= '0;
    end else begin
      mode <= mode_nxt;
      if (capture) hold_reg <= time_bcd;
    end
  end

  // Mode next-state: init_regs wins, split only acts while counting
  always_comb begin
    mode_nxt = mode;
    capture  = 1'b0;
    if (init_regs) begin
      mode_nxt = MODE_LIVE;
    end else if (split && count_enabled) begin
      case (mode)
        MODE_LIVE: begin
          mode_nxt = MODE_HOLD;
          capture  = 1'b1;
        end
        default: mode_nxt = MODE_LIVE;
      endcase
    end
  end

  // Blink timer: counts slot ticks while paused, starts in the visible phase
  always_ff @(posedge clk) begin
    if (reset || !paused) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (tick) begin
      if (blink_cnt == BLK_MAX) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Registered pin drive; blanked phase turns off anodes and decimal point
  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      seg <= seg_dec;
      if (blank) begin
        an <= AN_OFF;
        dp <= 1'b1;
      end else begin
        an <= ~(4'b0001 << sel);
        dp <= (sel != 2'd2);
      end
    end
  end

endmodule

// File: tb/tb_disp_sched.sv
// Randomized + directed bench for disp_sched with a cycle-level behavioural model.
module tb_disp_sched;

  localparam int RD = 4;
  localparam int BT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        count_enabled = 1'b0;
  logic        init_regs = 1'b0;
  logic        split = 1'b0;
  logic [15:0] time_bcd = 16'h0000;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int total = 0;
  int bad = 0;

  // model state: everything is derived from cycle/tick counts since reset
  int          m_cyc, m_ticks, m_ptk;
  bit          m_held;
  logic [15:0] m_hold;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;
  bit          e_segv;

  disp_sched #(.REFRESH_DIV(RD), .BLINK_TICKS(BT)) dut (
    .clk(clk), .reset(reset), .count_enabled(count_enabled), .init_regs(init_regs),
    .split(split), .time_bcd(time_bcd), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] digit_pattern(input logic [3:0] n);
    logic [6:0] t [0:9];
    t[0] = 7'b1000000; t[1] = 7'b1111001; t[2] = 7'b0100100; t[3] = 7'b0110000;
    t[4] = 7'b0011001; t[5] = 7'b0010010; t[6] = 7'b0000010; t[7] = 7'b1111000;
    t[8] = 7'b0000000; t[9] = 7'b0010000;
    if (n > 4'd9) return 7'b0111111;
    return t[n];
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Expected pins after the coming edge, then advance the model by one clock
  task automatic model_edge();
    int sel;
    logic [15:0] src;
    bit paused, visible, tick;
    if (reset) begin
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_segv = 1'b1;
      m_cyc = 0; m_ticks = 0; m_ptk = 0; m_held = 0; m_hold = 16'h0;
    end else begin
      sel     = m_ticks % 4;
      src     = m_held ? m_hold : time_bcd;
      paused  = !count_enabled && !init_regs;
      visible = !paused || ((m_ptk / BT) % 2 == 0);
      if (visible) begin
        e_an   = ~(4'b0001 << sel);
        e_dp   = (sel != 2);
        e_seg  = digit_pattern(src[4*sel +: 4]);
        e_segv = 1'b1;
      end else begin
        e_an = 4'hF; e_dp = 1'b1; e_segv = 1'b0;
      end
      tick = (m_cyc % RD) == RD - 1;
      m_cyc++;
      if (tick) m_ticks++;
      if (init_regs) m_held = 0;
      else if (split && count_enabled) begin
        if (!m_held) m_hold = time_bcd;
        m_held = !m_held;
      end
      if (!paused) m_ptk = 0;
      else if (tick) m_ptk++;
    end
  endtask

  // One clock: model prediction, edge, then compare just after the edge
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("an", an, e_an);
    chk("dp", dp, e_dp);
    if (e_segv) chk("seg", seg, e_seg);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_split();
    split = 1'b1;
    step();
    split = 1'b0;
  endtask

  initial begin
    bit found;
    @(negedge clk);
    reset = 1'b1;
    steps(3);
    chk("rst_an", an, 4'b1111);
    chk("rst_seg", seg, 7'b1111111);
    chk("rst_dp", dp, 1);

    // idle scan of 1234
    reset = 1'b0; init_regs = 1'b1; time_bcd = 16'h1234;
    step();
    chk("lit_an0", an, 4'b1110); chk("lit_seg0", seg, 7'b0011001);
    steps(4);
    chk("lit_an1", an, 4'b1101); chk("lit_seg1", seg, 7'b0110000);
    steps(4);
    chk("lit_an2", an, 4'b1011); chk("lit_seg2", seg, 7'b0100100); chk("lit_dp2", dp, 0);
    steps(4);
    chk("lit_an3", an, 4'b0111); chk("lit_seg3", seg, 7'b1111001);
    steps(4);
    chk("lit_wrap", an, 4'b1110);

    // split capture, freeze, release
    init_regs = 1'b0; count_enabled = 1'b1; time_bcd = 16'h0512;
    pulse_split();
    time_bcd = 16'h0999;
    steps(16);
    pulse_split();
    steps(16);

    // init overrides split
    init_regs = 1'b1; split = 1'b1;
    step();
    split = 1'b0; init_regs = 1'b0;
    steps(8);

    // pause blink then resume
    count_enabled = 1'b0;
    steps(32);
    count_enabled = 1'b1;
    steps(8);

    // dash on sel 1
    time_bcd = 16'h00A0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (e_an == 4'b1101) found = 1;
    end
    chk("dash_found", found, 1);
    chk("lit_dash", seg, 7'b0111111);

    // reset while held and blinking
    time_bcd = 16'h4321;
    pulse_split();
    time_bcd = 16'h5678;
    count_enabled = 1'b0;
    steps(13);
    reset = 1'b1;
    step();
    chk("midrst_an", an, 4'b1111);
    reset = 1'b0; count_enabled = 1'b1;
    steps(16);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      init_regs = ($urandom_range(0, 29) == 0);
      split     = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 39) == 0) count_enabled = ~count_enabled;
      if ($urandom_range(0, 9) == 0) time_bcd = 16'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
